// File: rtl/fecg_mat_pkg.sv
// Shared types for the fECG matrix datapath: element width, bank states and
// counter sizing.
package fecg_mat_pkg;
  localparam int N_BITS_DEF = 22;

  typedef logic [N_BITS_DEF-1:0] elem_t;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL
  } bank_state_e;

  // Index width for a counter over n entries; a 1-entry dimension still gets 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/transpose_bank.sv
// One SIZE_A x SIZE_B element store: written a row at a time, read a column at a time.
module transpose_bank
  import fecg_mat_pkg::*;
#(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int N_BITS = N_BITS_DEF,
  parameter int AW     = cnt_w(SIZE_A),
  parameter int BW     = cnt_w(SIZE_B)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en_i,
  input  logic [AW-1:0]                  wr_row_i,
  input  logic [SIZE_B-1:0][N_BITS-1:0]  wr_data_i,
  input  logic [BW-1:0]                  rd_col_i,
  output logic [SIZE_A-1:0][N_BITS-1:0]  rd_data_o
);

  logic [SIZE_A-1:0][SIZE_B-1:0][N_BITS-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (wr_en_i) begin
      for (int r = 0; r < SIZE_A; r++)
        if (wr_row_i == AW'(r)) mem_q[r] <= wr_data_i;
    end
  end

  // Compare-based select keeps 1-wide dimensions free of zero-width indices.
  always_comb begin
    rd_data_o = '0;
    for (int c = 0; c < SIZE_B; c++)
      if (rd_col_i == BW'(c))
        for (int r = 0; r < SIZE_A; r++) rd_data_o[r] = mem_q[r][c];
  end

endmodule

// File: rtl/transpose_stream.sv
// Streaming row-in / column-out matrix transposer with two ping-pong banks so
// matrix k+1 can be written while matrix k drains.
module transpose_stream
  import fecg_mat_pkg::*;
#(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SIZE_B-1:0][N_BITS-1:0]  in_row,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SIZE_A-1:0][N_BITS-1:0]  out_col,
  output logic                           out_last
);

  localparam int AW = cnt_w(SIZE_A);
  localparam int BW = cnt_w(SIZE_B);
  localparam logic [AW-1:0] ROW_LAST = AW'(SIZE_A - 1);
  localparam logic [BW-1:0] COL_LAST = BW'(SIZE_B - 1);

  bank_state_e   state_q [2];
  bank_state_e   state_d [2];
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_row_q, wr_row_d;
  logic [BW-1:0] rd_col_q, rd_col_d;

  logic          wr_fire, rd_fire;
  logic [1:0]    bank_we;
  logic [SIZE_A-1:0][N_BITS-1:0] bank_col [2];

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= BANK_EMPTY;
      state_q[1] <= BANK_EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_row_q   <= '0;
      rd_col_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_row_q   <= wr_row_d;
      rd_col_q   <= rd_col_d;
    end
  end

  // A full bank never accepts writes, so the write and read updates below
  // always touch different banks and can both apply in one cycle.
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_row_d  = wr_row_q;
    rd_col_d  = rd_col_q;
    if (flush) begin
      state_d[0] = BANK_EMPTY;
      state_d[1] = BANK_EMPTY;
      wr_bank_d  = 1'b0;
      rd_bank_d  = 1'b0;
      wr_row_d   = '0;
      rd_col_d   = '0;
    end else begin
      if (wr_fire) begin
        if (wr_row_q == ROW_LAST) begin
          state_d[wr_bank_q] = BANK_FULL;
          wr_row_d           = '0;
          wr_bank_d          = ~wr_bank_q;
        end else begin
          state_d[wr_bank_q] = BANK_FILLING;
          wr_row_d           = wr_row_q + AW'(1);
        end
      end
      if (rd_fire) begin
        if (rd_col_q == COL_LAST) begin
          state_d[rd_bank_q] = BANK_EMPTY;
          rd_col_d           = '0;
          rd_bank_d          = ~rd_bank_q;
        end else begin
          rd_col_d           = rd_col_q + BW'(1);
        end
      end
    end
  end

  always_comb begin
    in_ready  = (state_q[wr_bank_q] != BANK_FULL);
    out_valid = (state_q[rd_bank_q] == BANK_FULL);
    out_last  = out_valid && (rd_col_q == COL_LAST);
    out_col   = bank_col[rd_bank_q];
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = wr_fire && !flush && (wr_bank_q == 1'(b));

    transpose_bank #(
      .SIZE_A (SIZE_A),
      .SIZE_B (SIZE_B),
      .N_BITS (N_BITS),
      .AW     (AW),
      .BW     (BW)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (bank_we[b]),
      .wr_row_i  (wr_row_q),
      .wr_data_i (in_row),
      .rd_col_i  (rd_col_q),
      .rd_data_o (bank_col[b])
    );
  end

endmodule

// File: tb/tb_transpose_stream.sv
// Self-checking bench: an 8x8 instance checked against a row-queue/column-queue
// reference model, plus a 4x6 instance for the rectangular case.
module tb_transpose_stream;

  typedef logic [7:0][21:0] vec8_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, out_last;
  vec8_t       in_row = '0;
  vec8_t       out_col;

  logic             flush46 = 1'b0, in_valid46 = 1'b0, out_ready46 = 1'b0;
  logic             in_ready46, out_valid46, out_last46;
  logic [5:0][21:0] in_row46 = '0;
  logic [3:0][21:0] out_col46;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  transpose_stream #(.SIZE_A(8), .SIZE_B(8), .N_BITS(22)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_last(out_last)
  );

  transpose_stream #(.SIZE_A(4), .SIZE_B(6), .N_BITS(22)) u_dut46 (
    .clk(clk), .rst_n(rst_n), .flush(flush46), .in_valid(in_valid46), .in_ready(in_ready46),
    .in_row(in_row46), .out_valid(out_valid46), .out_ready(out_ready46), .out_col(out_col46),
    .out_last(out_last46)
  );

  // Reference model: rows collect until a matrix is complete, then its columns
  // join the output queue. m_full counts complete matrices not yet drained.
  vec8_t m_rows[$];
  vec8_t m_cols[$];
  int    m_full  = 0;
  int    m_rdpos = 0;

  function automatic void m_clear();
    m_rows.delete();
    m_cols.delete();
    m_full  = 0;
    m_rdpos = 0;
  endfunction

  function automatic void m_push_row(input vec8_t r);
    vec8_t c;
    m_rows.push_back(r);
    if (m_rows.size() == 8) begin
      for (int j = 0; j < 8; j++) begin
        for (int i = 0; i < 8; i++) c[i] = m_rows[i][j];
        m_cols.push_back(c);
      end
      m_rows.delete();
      m_full++;
    end
  endfunction

  function automatic void m_pop_col();
    void'(m_cols.pop_front());
    m_rdpos++;
    if (m_rdpos == 8) begin
      m_rdpos = 0;
      m_full--;
    end
  endfunction

  // {in_ready, out_valid, out_last} the model predicts for the current cycle.
  function automatic logic [2:0] exp_flags();
    return {m_full < 2, m_full > 0, (m_full > 0) && (m_rdpos == 7)};
  endfunction

  function automatic vec8_t mk_row(input int r);
    vec8_t v;
    for (int c = 0; c < 8; c++) v[c] = 22'(16 * r + c);
    return v;
  endfunction

  function automatic vec8_t rnd_row();
    vec8_t v;
    for (int c = 0; c < 8; c++) v[c] = 22'($urandom);
    return v;
  endfunction

  // Drive one cycle on the 8x8 instance (called at negedge), advance the model.
  task automatic tick8(input logic v, input vec8_t r, input logic rdy, input logic fl);
    logic wf, rf;
    wf = v && (m_full < 2);
    rf = rdy && (m_full > 0);
    in_valid  = v;
    in_row    = r;
    out_ready = rdy;
    flush     = fl;
    if (fl) m_clear();
    else begin
      if (rf) m_pop_col();
      if (wf) m_push_row(r);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last} !== 3'b100) begin
      errors++; $display("FAIL reset_flags8: got %b want 100", {in_ready, out_valid, out_last});
    end
    checks++;
    if (out_col !== '0) begin
      errors++; $display("FAIL reset_col8: got %h want 0", out_col);
    end
    checks++;
    if ({in_ready46, out_valid46, out_last46} !== 3'b100) begin
      errors++; $display("FAIL reset_flags46: got %b want 100", {in_ready46, out_valid46, out_last46});
    end
    checks++;
    if (out_col46 !== '0) begin
      errors++; $display("FAIL reset_col46: got %h want 0", out_col46);
    end
    rst_n = 1'b1;
    m_clear();
    @(negedge clk);
  endtask

  task automatic test_single();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        errors++; $display("FAIL single_fill row %0d: got rdy/vld %b want 10", i, {in_ready, out_valid});
      end
      tick8(1'b1, mk_row(i), 1'b1, 1'b0);
    end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if ({out_valid, out_last} !== {1'b1, j == 7}) begin
        errors++; $display("FAIL single_flags col %0d: got %b want %b", j, {out_valid, out_last}, {1'b1, j == 7});
      end
      for (int r = 0; r < 8; r++) begin
        checks++;
        if (out_col[r] !== 22'(16 * r + j)) begin
          errors++; $display("FAIL single_col %0d elem %0d: got %0d want %0d", j, r, out_col[r], 16 * r + j);
        end
      end
      tick8(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_end: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 33; k++) begin
      checks++;
      if ({in_ready, out_valid, out_last} !== {1'b1, k >= 8 && k < 32, k == 15 || k == 23 || k == 31}) begin
        errors++; $display("FAIL b2b_flags cycle %0d: got %b want %b", k, {in_ready, out_valid, out_last},
                           {1'b1, k >= 8 && k < 32, k == 15 || k == 23 || k == 31});
      end
      if (m_full > 0) begin
        checks++;
        if (out_col !== m_cols[0]) begin
          errors++; $display("FAIL b2b_col cycle %0d: got %h want %h", k, out_col, m_cols[0]);
        end
      end
      tick8(k < 24, rnd_row(), 1'b1, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 20; k++) begin
      checks++;
      if ({in_ready, out_valid, out_last} !== exp_flags() || (k >= 16 && in_ready !== 1'b0)) begin
        errors++; $display("FAIL bp_fill_flags cycle %0d: got %b want %b", k, {in_ready, out_valid, out_last}, exp_flags());
      end
      if (k >= 8) begin
        for (int r = 0; r < 8; r++) begin
          checks++;
          if (out_col[r] !== 22'(16 * r)) begin
            errors++; $display("FAIL bp_frozen cycle %0d elem %0d: got %0d want %0d", k, r, out_col[r], 16 * r);
          end
        end
      end
      tick8(k < 16, mk_row(k), 1'b0, 1'b0);
    end
    for (int k = 0; k < 18; k++) begin
      checks++;
      if ({in_ready, out_valid, out_last} !== exp_flags() || in_ready !== (k >= 8) || out_valid !== (k < 16)) begin
        errors++; $display("FAIL bp_drain_flags cycle %0d: got %b want %b", k, {in_ready, out_valid, out_last}, exp_flags());
      end
      if (m_full > 0) begin
        checks++;
        if (out_col !== m_cols[0]) begin
          errors++; $display("FAIL bp_drain_col cycle %0d: got %h want %h", k, out_col, m_cols[0]);
        end
      end
      tick8(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_rect();
    for (int r = 0; r < 4; r++) begin
      checks++;
      if ({in_ready46, out_valid46} !== 2'b10) begin
        errors++; $display("FAIL rect_fill row %0d: got %b want 10", r, {in_ready46, out_valid46});
      end
      in_valid46 = 1'b1;
      for (int c = 0; c < 6; c++) in_row46[c] = 22'(16 * r + c);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid46  = 1'b0;
    out_ready46 = 1'b1;
    for (int j = 0; j < 6; j++) begin
      checks++;
      if ({out_valid46, out_last46} !== {1'b1, j == 5}) begin
        errors++; $display("FAIL rect_flags col %0d: got %b want %b", j, {out_valid46, out_last46}, {1'b1, j == 5});
      end
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (out_col46[r] !== 22'(16 * r + j)) begin
          errors++; $display("FAIL rect_col %0d elem %0d: got %0d want %0d", j, r, out_col46[r], 16 * r + j);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready46 = 1'b0;
    checks++;
    if (out_valid46 !== 1'b0) begin
      errors++; $display("FAIL rect_end: out_valid got %b want 0", out_valid46);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 11; k++) tick8(1'b1, rnd_row(), 1'b0, 1'b0);
    tick8(1'b1, rnd_row(), 1'b1, 1'b1);
    checks++;
    if ({in_ready, out_valid, out_last} !== 3'b100) begin
      errors++; $display("FAIL flush_state: got %b want 100", {in_ready, out_valid, out_last});
    end
    for (int k = 0; k < 17; k++) begin
      checks++;
      if ({in_ready, out_valid, out_last} !== exp_flags() || out_valid !== (k >= 8 && k < 16)) begin
        errors++; $display("FAIL flush_after cycle %0d: got %b want %b", k, {in_ready, out_valid, out_last}, exp_flags());
      end
      if (m_full > 0) begin
        checks++;
        if (out_col !== m_cols[0]) begin
          errors++; $display("FAIL flush_col cycle %0d: got %h want %h", k, out_col, m_cols[0]);
        end
      end
      tick8(k < 8, rnd_row(), 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) tick8(1'b1, rnd_row(), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick8(1'b0, '0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_last} !== 3'b100) begin
      errors++; $display("FAIL rstmid_flags: got %b want 100", {in_ready, out_valid, out_last});
    end
    checks++;
    if (out_col !== '0) begin
      errors++; $display("FAIL rstmid_col: got %h want 0", out_col);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    @(negedge clk);
    for (int k = 0; k < 17; k++) begin
      checks++;
      if ({in_ready, out_valid, out_last} !== exp_flags()) begin
        errors++; $display("FAIL rstmid_after cycle %0d: got %b want %b", k, {in_ready, out_valid, out_last}, exp_flags());
      end
      if (m_full > 0) begin
        checks++;
        if (out_col !== m_cols[0]) begin
          errors++; $display("FAIL rstmid_col cycle %0d: got %h want %h", k, out_col, m_cols[0]);
        end
      end
      tick8(k < 8, rnd_row(), 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 900; k++) begin
      checks++;
      if ({in_ready, out_valid, out_last} !== exp_flags()) begin
        errors++; $display("FAIL rand_flags cycle %0d: got %b want %b", k, {in_ready, out_valid, out_last}, exp_flags());
      end
      if (m_full > 0) begin
        checks++;
        if (out_col !== m_cols[0]) begin
          errors++; $display("FAIL rand_col cycle %0d: got %h want %h", k, out_col, m_cols[0]);
        end
      end
      tick8($urandom_range(0, 3) != 0, rnd_row(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 149) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_rect();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
